imm_decode_stage: RTL

- Registered, parametrised immediate-decode stage for the RV fetch/decode path.
- Accepts {pc, instruction} on a valid/ready input and extracts and extends the immediate to XLEN.
- Classifies the format, flags unsupported opcodes, and computes pc+imm as a target candidate.
- Output is a 2-entry elastic buffer (main + skid) with synchronous flush and a saturating illegal-opcode counter.

---
 rtl/imm_decode_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// Immediate-decode stage: extracts/extends RV immediates, classifies format, computes pc+imm,
// and presents results through a 2-entry elastic buffer. Define IMM_DECODE_CSR_EN to decode CSR*I uimm.
module imm_decode_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_imm_type,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
`ifdef IMM_DECODE_CSR_EN
    localparam logic [2:0] T_Z    = 3'd6;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic [XLEN-1:0]    dec_imm;
    logic [2:0]         dec_type;
    logic               dec_illegal;
    entry_t             dec_entry;

    entry_t             main_q;
    entry_t             skid_q;
    logic               main_v;
    logic               skid_v;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;

    assign imm_i = in_instr[31:20];
    assign imm_s = {in_instr[31:25], in_instr[11:7]};
    assign imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Format classification; signed size casts sign-extend from each format's MSB.
    always_comb begin
        dec_imm     = '0;
        dec_type    = T_NONE;
        dec_illegal = 1'b1;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                7'b0000011, 7'b0010011, 7'b1100111: begin
                    dec_imm = XLEN'(imm_i); dec_type = T_I; dec_illegal = 1'b0;
                end
                7'b0011011: begin
                    if (XLEN == 64) begin
                        dec_imm = XLEN'(imm_i); dec_type = T_I; dec_illegal = 1'b0;
                    end
                end
                7'b0100011: begin
                    dec_imm = XLEN'(imm_s); dec_type = T_S; dec_illegal = 1'b0;
                end
                7'b1100011: begin
                    dec_imm = XLEN'(imm_b); dec_type = T_B; dec_illegal = 1'b0;
                end
                7'b0110111, 7'b0010111: begin
                    dec_imm = XLEN'(imm_u); dec_type = T_U; dec_illegal = 1'b0;
                end
                7'b1101111: begin
                    dec_imm = XLEN'(imm_j); dec_type = T_J; dec_illegal = 1'b0;
                end
`ifdef IMM_DECODE_CSR_EN
                7'b1110011: begin
                    if (in_instr[14]) begin
                        dec_imm = XLEN'(in_instr[19:15]); dec_type = T_Z; dec_illegal = 1'b0;
                    end
                end
`endif
                default: begin
                    dec_imm     = '0;
                    dec_type    = T_NONE;
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        dec_entry          = '0;
        dec_entry.pc       = in_pc;
        dec_entry.instr    = in_instr;
        dec_entry.imm      = dec_imm;
        dec_entry.imm_type = dec_type;
        dec_entry.target   = in_pc + dec_imm;
        dec_entry.illegal  = dec_illegal;
    end

    assign in_ready = !skid_v && !rst;
    assign accept   = in_valid && in_ready;

    // Main/skid elastic buffer; flush outranks both accept and downstream ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (out_ready || !main_v) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= accept;
                if (accept) begin
                    skid_q <= dec_entry;
                end
            end else begin
                main_v <= accept;
                if (accept) begin
                    main_q <= dec_entry;
                end
            end
        end else if (accept) begin
            skid_q <= dec_entry;
            skid_v <= 1'b1;
        end
    end

    // Saturating count of illegal entries that survive into the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && !flush && dec_illegal && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid    = main_v;
    assign out_pc       = main_q.pc;
    assign out_instr    = main_q.instr;
    assign out_imm      = main_q.imm;
    assign out_imm_type = main_q.imm_type;
    assign out_target   = main_q.target;
    assign out_illegal  = main_q.illegal;
    assign illegal_cnt  = cnt_q;

endmodule
